// File: rtl/noc_route_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : noc_route_pkg
//  Purpose  : Shared codes for the NoC route-computation stage: routing mode
//             selectors, output port codes, one-hot request bit positions,
//             wormhole flit type codes, FSM states and a port-to-request
//             helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package noc_route_pkg;

  // Routing order selector for ROUTE_MODE.
  localparam int ROUTE_XY = 0;
  localparam int ROUTE_YX = 1;

  // Output port codes; 0 is reserved for "no port" while the stage is empty.
  localparam logic [2:0] c_port_none  = 3'd0;
  localparam logic [2:0] c_port_local = 3'd1;
  localparam logic [2:0] c_port_north = 3'd2;
  localparam logic [2:0] c_port_south = 3'd3;
  localparam logic [2:0] c_port_east  = 3'd4;
  localparam logic [2:0] c_port_west  = 3'd5;

  // Bit positions inside the one-hot request vector.
  localparam int c_req_local = 0;
  localparam int c_req_north = 1;
  localparam int c_req_south = 2;
  localparam int c_req_east  = 3;
  localparam int c_req_west  = 4;

  // Wormhole flit type codes.
  localparam logic [1:0] c_flit_body   = 2'b00;
  localparam logic [1:0] c_flit_tail   = 2'b01;
  localparam logic [1:0] c_flit_head   = 2'b10;
  localparam logic [1:0] c_flit_single = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_PACKET = 1'b1
  } route_state_t;

  // One-hot arbiter request for a port code; unknown codes request nothing.
  function automatic logic [4:0] port_to_req(input logic [2:0] port);
    logic [4:0] r;
    r = '0;
    case (port)
      c_port_local: r[c_req_local] = 1'b1;
      c_port_north: r[c_req_north] = 1'b1;
      c_port_south: r[c_req_south] = 1'b1;
      c_port_east:  r[c_req_east]  = 1'b1;
      c_port_west:  r[c_req_west]  = 1'b1;
      default:      r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/route_calc.sv
`default_nettype none
// ============================================================================
//  Module   : route_calc
//  Purpose  : Combinational dimension-order route computation. Resolves the
//             signed relative {y, x} offset into an output port, a one-hot
//             arbiter request and the address after one hop.
//  Ports    : addr      in   {y, x} signed relative offsets
//             port      out  output port code (1 local .. 5 west)
//             req       out  one-hot request {west,east,south,north,local}
//             next_addr out  offset rewritten for the next router
//  Revision : 1.0  initial release
// ============================================================================
module route_calc
  import noc_route_pkg::*;
#(
  parameter int X_W        = 8,
  parameter int Y_W        = 8,
  parameter int ROUTE_MODE = ROUTE_XY
) (
  input  logic [X_W+Y_W-1:0] addr,
  output logic [2:0]         port,
  output logic [4:0]         req,
  output logic [X_W+Y_W-1:0] next_addr
);

  localparam logic [X_W-1:0] c_x_one = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] c_y_one = {{(Y_W-1){1'b0}}, 1'b1};

  logic [X_W-1:0] w_x;
  logic [X_W-1:0] w_x_step;
  logic [Y_W-1:0] w_y;
  logic [Y_W-1:0] w_y_step;
  logic           w_x_nz;
  logic           w_y_nz;
  logic           w_x_first;

  assign w_x    = addr[X_W-1:0];
  assign w_y    = addr[X_W+Y_W-1:X_W];
  assign w_x_nz = |w_x;
  assign w_y_nz = |w_y;

  // One hop toward zero: negative offsets increment, positive ones
  // decrement, so neither direction can wrap (the most negative value
  // simply becomes one less negative).
  assign w_x_step = w_x[X_W-1] ? (w_x + c_x_one) : (w_x - c_x_one);
  assign w_y_step = w_y[Y_W-1] ? (w_y + c_y_one) : (w_y - c_y_one);

  generate
    if (ROUTE_MODE == ROUTE_YX) begin : g_yx_order
      assign w_x_first = 1'b0;
    end else begin : g_xy_order
      assign w_x_first = 1'b1;
    end
  endgenerate

  // X is resolved when it is the leading dimension, or when it is the
  // trailing one and Y has already reached zero.
  always_comb begin
    port      = c_port_local;
    next_addr = addr;
    if (w_x_nz && (w_x_first || !w_y_nz)) begin
      port      = w_x[X_W-1] ? c_port_west : c_port_east;
      next_addr = {w_y, w_x_step};
    end else if (w_y_nz) begin
      port      = w_y[Y_W-1] ? c_port_south : c_port_north;
      next_addr = {w_y_step, w_x};
    end
  end

  assign req = port_to_req(port);

endmodule
`default_nettype wire

// File: rtl/route_compute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : route_compute_stage
//  Purpose  : Registered route-computation stage of the NoC router input
//             path. Routes head/single flits, locks the route for the rest
//             of the packet, and buffers through an output register plus a
//             one-entry skid register for full throughput under backpressure.
//  Ports    : clk, rst_n                  clock / async active-low reset
//             in_valid/in_ready           input handshake
//             in_type/in_addr/in_data     input flit
//             out_valid/out_ready         output handshake
//             out_type/out_addr/out_data  output flit (addr rewritten on heads)
//             out_port/out_req            routed port code / one-hot request
//             busy                        packet route currently locked
//             err                         one-cycle protocol violation pulse
//  Revision : 1.0  initial release
// ============================================================================
module route_compute_stage
  import noc_route_pkg::*;
#(
  parameter int X_W        = 8,
  parameter int Y_W        = 8,
  parameter int DATA_W     = 32,
  parameter int ROUTE_MODE = ROUTE_XY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_type,
  input  logic [X_W+Y_W-1:0] in_addr,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_type,
  output logic [X_W+Y_W-1:0] out_addr,
  output logic [DATA_W-1:0]  out_data,
  output logic [2:0]         out_port,
  output logic [4:0]         out_req,
  output logic               busy,
  output logic               err
);

  localparam int c_addr_w = X_W + Y_W;

  route_state_t        r_state;
  route_state_t        w_state_nx;

  logic                w_accept;
  logic                w_head_like;
  logic                w_ends;
  logic                w_drop;
  logic                w_violation;
  logic                w_push;
  logic                w_out_load;

  logic [2:0]          w_calc_port;
  logic [4:0]          w_calc_req;
  logic [c_addr_w-1:0] w_calc_addr;

  logic [2:0]          w_new_port;
  logic [4:0]          w_new_req;
  logic [c_addr_w-1:0] w_new_addr;

  logic [2:0]          r_lock_port;
  logic [4:0]          r_lock_req;
  logic                r_err;

  logic                r_out_valid;
  logic [1:0]          r_out_type;
  logic [c_addr_w-1:0] r_out_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic [2:0]          r_out_port;
  logic [4:0]          r_out_req;

  logic                r_skid_valid;
  logic [1:0]          r_skid_type;
  logic [c_addr_w-1:0] r_skid_addr;
  logic [DATA_W-1:0]   r_skid_data;
  logic [2:0]          r_skid_port;
  logic [4:0]          r_skid_req;

  route_calc #(
    .X_W        (X_W),
    .Y_W        (Y_W),
    .ROUTE_MODE (ROUTE_MODE)
  ) u_route_calc (
    .addr      (in_addr),
    .port      (w_calc_port),
    .req       (w_calc_req),
    .next_addr (w_calc_addr)
  );

  // --------------------------------------------------------------------------
  // Flit classification
  // --------------------------------------------------------------------------
  assign in_ready    = !r_skid_valid;
  assign w_accept    = in_valid && in_ready;
  assign w_head_like = (in_type == c_flit_head) || (in_type == c_flit_single);
  assign w_ends      = (in_type == c_flit_tail) || (in_type == c_flit_single);

  // A body/tail with no open packet has no route to follow and is dropped.
  assign w_drop      = (r_state == ST_IDLE) && !w_head_like;
  assign w_violation = w_drop || ((r_state == ST_PACKET) && w_head_like);
  assign w_push      = w_accept && !w_drop;

  assign w_new_port  = w_head_like ? w_calc_port : r_lock_port;
  assign w_new_req   = w_head_like ? w_calc_req  : r_lock_req;
  assign w_new_addr  = w_head_like ? w_calc_addr : in_addr;

  // --------------------------------------------------------------------------
  // Packet FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // A single flit arriving mid-packet restarts the route and, being a tail
  // as well, closes the packet.
  always_comb begin
    w_state_nx = r_state;
    if (w_accept) begin
      case (r_state)
        ST_IDLE:   if (in_type == c_flit_head) w_state_nx = ST_PACKET;
        ST_PACKET: if (w_ends)                 w_state_nx = ST_IDLE;
        default:   w_state_nx = ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_PACKET);

  // --------------------------------------------------------------------------
  // Route lock and error pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_port <= c_port_none;
      r_lock_req  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_accept && w_violation;
      if (w_accept && w_head_like) begin
        r_lock_port <= w_calc_port;
        r_lock_req  <= w_calc_req;
      end
    end
  end

  assign err = r_err;

  // --------------------------------------------------------------------------
  // Output register + skid register
  // --------------------------------------------------------------------------
  // The output register reloads whenever it is empty or being drained. The
  // skid entry is older than any new input, so it always goes first; while
  // it is occupied in_ready is low, so no push can collide with it.
  assign w_out_load = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_type   <= '0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_out_port   <= c_port_none;
      r_out_req    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_type  <= '0;
      r_skid_addr  <= '0;
      r_skid_data  <= '0;
      r_skid_port  <= c_port_none;
      r_skid_req   <= '0;
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_type   <= r_skid_type;
        r_out_addr   <= r_skid_addr;
        r_out_data   <= r_skid_data;
        r_out_port   <= r_skid_port;
        r_out_req    <= r_skid_req;
        r_skid_valid <= 1'b0;
      end else if (w_push) begin
        r_out_valid  <= 1'b1;
        r_out_type   <= in_type;
        r_out_addr   <= w_new_addr;
        r_out_data   <= in_data;
        r_out_port   <= w_new_port;
        r_out_req    <= w_new_req;
      end else begin
        // Port and request read as zero whenever nothing is presented.
        r_out_valid  <= 1'b0;
        r_out_port   <= c_port_none;
        r_out_req    <= '0;
      end
    end else if (w_push) begin
      r_skid_valid <= 1'b1;
      r_skid_type  <= in_type;
      r_skid_addr  <= w_new_addr;
      r_skid_data  <= in_data;
      r_skid_port  <= w_new_port;
      r_skid_req   <= w_new_req;
    end
  end

  assign out_valid = r_out_valid;
  assign out_type  = r_out_type;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign out_port  = r_out_port;
  assign out_req   = r_out_req;

endmodule
`default_nettype wire

// File: tb/tb_route_compute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_route_compute_stage
//  Purpose  : Self-checking bench for route_compute_stage. Drives an XY and
//             a YX instance with identical traffic and compares both against
//             a flit-queue reference model of the stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_route_compute_stage;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_type;
  logic [15:0] in_addr;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready  [2];
  logic        out_valid [2];
  logic [1:0]  out_type  [2];
  logic [15:0] out_addr  [2];
  logic [31:0] out_data  [2];
  logic [2:0]  out_port  [2];
  logic [4:0]  out_req   [2];
  logic        busy      [2];
  logic        err       [2];

  always #5 clk = ~clk;

  route_compute_stage #(.X_W(8), .Y_W(8), .DATA_W(32), .ROUTE_MODE(0)) u_dut_xy (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_type(in_type), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_type(out_type[0]), .out_addr(out_addr[0]), .out_data(out_data[0]),
    .out_port(out_port[0]), .out_req(out_req[0]),
    .busy(busy[0]), .err(err[0])
  );

  route_compute_stage #(.X_W(8), .Y_W(8), .DATA_W(32), .ROUTE_MODE(1)) u_dut_yx (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_type(in_type), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_type(out_type[1]), .out_addr(out_addr[1]), .out_data(out_data[1]),
    .out_port(out_port[1]), .out_req(out_req[1]),
    .busy(busy[1]), .err(err[1])
  );

  // --------------------------------------------------------------------------
  // Reference model state
  // --------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  t;
    logic [15:0] a;
    logic [31:0] d;
    logic [2:0]  p;
    logic [4:0]  r;
  } flit_t;

  flit_t q0[$];
  flit_t q1[$];
  bit    in_pkt;
  int    lock_p [2];
  bit    exp_err;
  bit    exp_err_nx;
  bit    last_acc;
  int    n_total;
  int    n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Dimension-order routing written straight from the rules: one hop toward
  // zero in the first non-zero dimension of the chosen order.
  function automatic void ref_route(input int mode, input logic [15:0] a,
                                    output int port, output logic [15:0] na);
    int x;
    int y;
    x = $signed(a[7:0]);
    y = $signed(a[15:8]);
    port = 1;
    if (mode == 0) begin
      if      (x > 0) begin port = 4; x = x - 1; end
      else if (x < 0) begin port = 5; x = x + 1; end
      else if (y > 0) begin port = 2; y = y - 1; end
      else if (y < 0) begin port = 3; y = y + 1; end
    end else begin
      if      (y > 0) begin port = 2; y = y - 1; end
      else if (y < 0) begin port = 3; y = y + 1; end
      else if (x > 0) begin port = 4; x = x - 1; end
      else if (x < 0) begin port = 5; x = x + 1; end
    end
    na = {8'(y), 8'(x)};
  endfunction

  task automatic model_accept();
    bit    head_like;
    bit    ends;
    int    p;
    flit_t f;
    head_like = (in_type == T_HEAD) || (in_type == T_SINGLE);
    ends      = (in_type == T_TAIL) || (in_type == T_SINGLE);
    if (!in_pkt && !head_like) begin
      exp_err_nx = 1'b1;
      return;
    end
    if (in_pkt && head_like) exp_err_nx = 1'b1;
    for (int m = 0; m < 2; m++) begin
      f.t = in_type;
      f.d = in_data;
      if (head_like) begin
        ref_route(m, in_addr, p, f.a);
        lock_p[m] = p;
      end else begin
        p   = lock_p[m];
        f.a = in_addr;
      end
      f.p = 3'(p);
      f.r = 5'(1 << (p - 1));
      if (m == 0) q0.push_back(f); else q1.push_back(f);
    end
    if (in_type == T_HEAD) in_pkt = 1'b1;
    else if (ends)         in_pkt = 1'b0;
  endtask

  task automatic check_outs(input int m);
    string pfx;
    int    n;
    flit_t f;
    pfx = (m == 0) ? "xy_" : "yx_";
    n   = (m == 0) ? q0.size() : q1.size();
    chk({pfx, "in_ready"}, in_ready[m], n < 2);
    chk({pfx, "out_valid"}, out_valid[m], n > 0);
    chk({pfx, "err"}, err[m], exp_err);
    chk({pfx, "busy"}, busy[m], in_pkt);
    if (n > 0) begin
      f = (m == 0) ? q0[0] : q1[0];
      chk({pfx, "out_type"}, out_type[m], f.t);
      chk({pfx, "out_addr"}, out_addr[m], f.a);
      chk({pfx, "out_data"}, out_data[m], f.d);
      chk({pfx, "out_port"}, out_port[m], f.p);
      chk({pfx, "out_req"},  out_req[m],  f.r);
    end else begin
      chk({pfx, "idle_port"}, out_port[m], 0);
      chk({pfx, "idle_req"},  out_req[m],  0);
    end
  endtask

  // One clock: check at the falling edge, advance the model with the
  // handshakes seen there, return 1 time unit after the rising edge.
  task automatic cycle();
    bit acc;
    bit fire;
    @(negedge clk);
    check_outs(0);
    check_outs(1);
    acc  = in_valid && (q0.size() < 2);
    fire = (q0.size() > 0) && out_ready;
    if (fire) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    exp_err_nx = 1'b0;
    if (acc) model_accept();
    @(posedge clk);
    #1;
    exp_err  = exp_err_nx;
    last_acc = acc;
  endtask

  task automatic send(input logic [1:0] t, input logic [15:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_type  = t;
    in_addr  = a;
    in_data  = d;
    last_acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_acc) break;
    end
    chk("send_accepted", last_acc, 1);
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] pick_off();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'h7F;
      3: return 8'h01;
      4: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic gen_flit();
    int r;
    r = $urandom_range(0, 99);
    if (!in_pkt) in_type = (r < 45) ? T_HEAD : (r < 90) ? T_SINGLE : (r < 95) ? T_BODY : T_TAIL;
    else         in_type = (r < 50) ? T_BODY : (r < 90) ? T_TAIL : T_HEAD;
    in_addr  = {pick_off(), pick_off()};
    in_data  = $urandom;
    in_valid = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [1:0] bp_t [5];
  int         idx;
  bit         saw_low;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_type   = 2'b00;
    in_addr   = 16'h0000;
    in_data   = 32'h0;
    out_ready = 1'b0;
    n_total   = 0;
    n_bad     = 0;
    in_pkt    = 1'b0;
    exp_err   = 1'b0;
    last_acc  = 1'b0;
    lock_p[0] = 0;
    lock_p[1] = 0;

    // ---------------- reset values ----------------
    #12;
    for (int m = 0; m < 2; m++) begin
      chk("rst_out_valid", out_valid[m], 0);
      chk("rst_out_type",  out_type[m],  0);
      chk("rst_out_addr",  out_addr[m],  0);
      chk("rst_out_data",  out_data[m],  0);
      chk("rst_out_port",  out_port[m],  0);
      chk("rst_out_req",   out_req[m],   0);
      chk("rst_busy",      busy[m],      0);
      chk("rst_err",       err[m],       0);
      chk("rst_in_ready",  in_ready[m],  1);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- routing examples ----------------
    out_ready = 1'b1;
    send(T_HEAD, 16'hFE03, 32'hA000_0001);
    chk("xy_head_port", out_port[0], 4);
    chk("xy_head_req",  out_req[0],  5'b01000);
    chk("xy_head_addr", out_addr[0], 16'hFE02);
    chk("yx_head_port", out_port[1], 3);
    chk("yx_head_req",  out_req[1],  5'b00100);
    chk("yx_head_addr", out_addr[1], 16'hFF03);
    send(T_TAIL, 16'h1234, 32'hA000_0002);
    send(T_SINGLE, 16'h0000, 32'hA000_0003);
    chk("yx_single_port", out_port[1], 1);
    chk("yx_single_req",  out_req[1],  5'b00001);
    chk("yx_single_addr", out_addr[1], 16'h0000);
    cycle();

    // ---------------- extreme negative x, back-to-back packet ----------------
    send(T_HEAD, 16'h0080, 32'hB000_0000);
    chk("neg_head_addr", out_addr[0], 16'h0081);
    chk("neg_head_port", out_port[0], 5);
    chk("neg_busy_head", busy[0], 1);
    send(T_BODY, 16'h5555, 32'hB000_0001);
    chk("neg_body_port", out_port[0], 5);
    chk("neg_body_addr", out_addr[0], 16'h5555);
    send(T_BODY, 16'h6666, 32'hB000_0002);
    chk("neg_body2_valid", out_valid[0], 1);
    send(T_TAIL, 16'h7777, 32'hB000_0003);
    chk("neg_tail_port", out_port[1], 5);
    chk("neg_tail_addr", out_addr[1], 16'h7777);
    chk("neg_busy_tail", busy[0], 0);
    cycle();

    // ---------------- backpressure: 5 flits, stall cycles 2-5 ----------------
    bp_t[0] = T_HEAD; bp_t[1] = T_BODY; bp_t[2] = T_BODY; bp_t[3] = T_BODY; bp_t[4] = T_TAIL;
    idx      = 0;
    saw_low  = 1'b0;
    in_valid = 1'b1;
    in_type  = bp_t[0];
    in_addr  = 16'h0203;
    in_data  = 32'hC000_0000;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 5);
      cycle();
      if (!in_ready[0]) saw_low = 1'b1;
      if (last_acc) begin
        idx++;
        if (idx < 5) begin
          in_type = bp_t[idx];
          in_addr = 16'(16'h1000 + idx);
          in_data = 32'hC000_0000 + 32'(idx);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (idx == 5 && q0.size() == 0) break;
    end
    chk("bp_all_sent", idx, 5);
    chk("bp_in_ready_dropped", saw_low, 1);
    chk("bp_drained", q0.size(), 0);
    out_ready = 1'b1;
    cycle();

    // ---------------- protocol violations ----------------
    send(T_BODY, 16'h0001, 32'hD000_0000);
    chk("viol_body_err", err[0], 1);
    chk("viol_body_dropped", out_valid[0], 0);
    chk("viol_body_idle", busy[0], 0);
    cycle();
    chk("viol_body_err_1cyc", err[0], 0);
    send(T_HEAD, 16'h0002, 32'hD000_0001);
    send(T_HEAD, 16'h00FD, 32'hD000_0002);
    chk("viol_head_err", err[1], 1);
    chk("viol_head_newport", out_port[0], 5);
    chk("viol_head_newaddr", out_addr[0], 16'h00FE);
    chk("viol_head_busy", busy[0], 1);
    send(T_TAIL, 16'h0000, 32'hD000_0003);
    cycle();

    // ---------------- reset mid-packet ----------------
    out_ready = 1'b0;
    send(T_HEAD, 16'h0100, 32'hE000_0000);
    send(T_BODY, 16'h0000, 32'hE000_0001);
    #3 rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    in_pkt  = 1'b0;
    exp_err = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("arst_out_valid", out_valid[m], 0);
      chk("arst_out_port",  out_port[m],  0);
      chk("arst_out_req",   out_req[m],   0);
      chk("arst_out_addr",  out_addr[m],  0);
      chk("arst_busy",      busy[m],      0);
      chk("arst_in_ready",  in_ready[m],  1);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    send(T_TAIL, 16'h0000, 32'hE000_0002);
    chk("arst_tail_err", err[0], 1);
    chk("arst_tail_dropped", out_valid[0], 0);
    cycle();

    // ---------------- randomized traffic ----------------
    in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid && ($urandom_range(0, 3) != 0)) gen_flit();
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (last_acc) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_drained", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
